// File: rtl/fir_mac_sequencer.sv
// FIR multiply-accumulate sequencer.
// Accepts one sample at a time into a TAPS-deep delay line. It then walks
// the taps with a single MAC, one tap per cycle, and presents the scaled,
// saturated result until the consumer takes it.
module fir_mac_sequencer #(
    parameter int TAPS = 8,
    localparam int AW = $clog2(TAPS)
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [7:0]    Xn,
    input  logic          coef_we,
    input  logic [AW-1:0] coef_addr,
    input  logic [7:0]    coef_wdata,
    output logic          coef_err,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [7:0]    Yn,
    output logic          busy
);

    // 16-bit products summed over TAPS terms need AW extra bits of headroom.
    localparam int ACCW = 17 + AW;
    // Width of the accumulator after dropping the 7 Q1.7 fraction bits.
    localparam int SW = ACCW - 7;
    localparam logic [AW-1:0] TAP_LAST = AW'(TAPS - 1);
    localparam logic [AW-1:0] TAP_ONE  = AW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q;
    logic [ACCW-1:0]   acc_q;
    logic [AW-1:0]     tap_q;
    logic [7:0]        yn_q;
    logic              coef_err_q;
    logic [7:0]        x_q [TAPS];
    logic [7:0]        c_q [TAPS];

    logic [7:0]        x_sel;
    logic [7:0]        c_sel;
    logic [15:0]       x_ext;
    logic [15:0]       c_ext;
    logic [15:0]       prod;
    logic [ACCW-1:0]   acc_d;
    logic [SW-1:0]     scaled;
    logic [7:0]        yn_d;

    // MAC datapath: product of the current tap, running sum, and the
    // floor-scaled, saturated result that is captured on the last tap.
    always_comb begin
        x_sel  = x_q[tap_q];
        c_sel  = c_q[tap_q];
        x_ext  = {{8{x_sel[7]}}, x_sel};
        c_ext  = {{8{c_sel[7]}}, c_sel};
        prod   = x_ext * c_ext;
        acc_d  = acc_q + {{(ACCW-16){prod[15]}}, prod};
        scaled = acc_d[ACCW-1:7];
        yn_d   = scaled[7:0];
        if (scaled[SW-1:7] != {(SW-7){scaled[7]}}) begin
            yn_d = scaled[SW-1] ? 8'h80 : 8'h7F;
        end
    end

    // Sequencer FSM together with the delay line, coefficient file and accumulator.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            tap_q      <= '0;
            yn_q       <= '0;
            coef_err_q <= 1'b0;
            for (int i = 0; i < TAPS; i++) begin
                x_q[i] <= '0;
                c_q[i] <= '0;
            end
        end else begin
            coef_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (coef_we) begin
                        c_q[coef_addr] <= coef_wdata;
                    end
                    if (in_valid) begin
                        x_q[0] <= Xn;
                        for (int i = 1; i < TAPS; i++) begin
                            x_q[i] <= x_q[i-1];
                        end
                        acc_q   <= '0;
                        tap_q   <= '0;
                        state_q <= MAC;
                    end
                end
                MAC: begin
                    coef_err_q <= coef_we;
                    acc_q      <= acc_d;
                    if (tap_q == TAP_LAST) begin
                        tap_q   <= '0;
                        yn_q    <= yn_d;
                        state_q <= DONE;
                    end else begin
                        tap_q <= tap_q + TAP_ONE;
                    end
                end
                DONE: begin
                    coef_err_q <= coef_we;
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign Yn        = yn_q;
    assign coef_err  = coef_err_q;

endmodule

// File: doc/fir_mac_sequencer.md
FIR_MAC_SEQUENCER -- requirements
Module: fir_mac_sequencer

Interface
REQ-001 Parameter TAPS, default 8, filter length; SHALL be a power of two in 2..16; AW = log2(TAPS).
REQ-002 Port CLK  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 Port RST  input  1  reset, asynchronous assertion, active-low (RST=0 resets).
REQ-004 Port in_valid  input  1  Xn carries a sample.
REQ-005 Port in_ready  output  1  sequencer can accept a sample this cycle.
REQ-006 Port Xn  input  8  input sample, signed two's complement.
REQ-007 Port coef_we  input  1  coefficient write strobe.
REQ-008 Port coef_addr  input  AW  coefficient index.
REQ-009 Port coef_wdata  input  8  coefficient, signed Q1.7.
REQ-010 Port coef_err  output  1  one-cycle pulse: coefficient write dropped.
REQ-011 Port out_valid  output  1  Yn holds a result.
REQ-012 Port out_ready  input  1  consumer accepts Yn.
REQ-013 Port Yn  output  8  filtered sample, signed two's complement.
REQ-014 Port busy  output  1  high whenever state is not IDLE.

Function
REQ-015 Block SHALL hold a TAPS-entry sample delay line x[0..TAPS-1] (x[0] newest), a TAPS-entry coefficient file c[0..TAPS-1], and one multiply-accumulate datapath used once per cycle.
REQ-016 FSM states SHALL be IDLE, MAC, DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-017 IDLE: on edge with in_valid=1, SHALL shift delay line (x[i]<=x[i-1], x[0]<=Xn), clear accumulator, clear tap counter, go to MAC; otherwise stay.
REQ-018 MAC: each cycle SHALL add c[t]*x[t] (signed 8x8 -> 16-bit) to accumulator and increment tap counter t; after t=TAPS-1 accumulates, go to DONE with Yn registered.
REQ-019 Accumulator SHALL be 17+AW bits signed; no overflow possible.
REQ-020 Yn SHALL equal accumulator arithmetically shifted right by 7 (truncation toward minus infinity), then saturated to [-128, 127].
REQ-021 Latency: out_valid SHALL rise exactly TAPS cycles after the accepting edge.
REQ-022 DONE: Yn and out_valid SHALL hold stable until an edge with out_ready=1, then go to IDLE; in_ready stays 0 throughout DONE.
REQ-023 Minimum sample period SHALL be TAPS+2 cycles with out_ready held 1.
REQ-024 coef_we in IDLE SHALL write c[coef_addr]<=coef_wdata at that edge; coef_we in MAC or DONE SHALL be ignored and coef_err pulsed high for the following cycle.
REQ-025 Simultaneous coef_we and accepted sample in IDLE: write SHALL take effect and be used by that sample's computation.
REQ-026 in_valid while not IDLE SHALL have no effect (sample not consumed, delay line unchanged).
REQ-027 Tap counter SHALL wrap to 0 on leaving MAC; no state other than the three named SHALL be reachable.

Reset
REQ-028 RST=0 SHALL immediately force: state IDLE, in_ready 1 (once RST=1), out_valid 0, Yn 0x00, busy 0, coef_err 0, delay line all 0, coefficients all 0x00, accumulator and tap counter 0.
REQ-029 RST asserted mid-MAC or in DONE SHALL discard the pending result; no out_valid SHALL follow release.
REQ-030 After RST release, first accept SHALL be possible on the first rising edge with in_valid=1.

Verification
REQ-031 Reset defaults: after reset, Xn=0x55 accepted -> out_valid 8 cycles later, Yn=0x00.
REQ-032 Impulse: c[i]=0x10*i (i=0..7), feed 0x40 then seven 0x00, out_ready=1 -> Yn sequence 0x00,0x08,0x10,0x18,0x20,0x28,0x30,0x38.
REQ-033 Saturation: c[0]=0x80, Xn=0x80 -> Yn=0x7F; c[0]=c[1]=0x7F, others 0, samples 0x80,0x80 -> second Yn=0x80 (first 0x81).
REQ-034 Backpressure: out_ready=0 for 5 cycles in DONE with in_valid=1 -> Yn, out_valid stable, in_ready 0, no sample consumed; transfer on out_ready=1, IDLE next cycle.
REQ-035 Coefficient write while busy: coef_we in MAC -> c unchanged, coef_err high exactly one cycle; same-edge write+accept in IDLE (c[0]=0x40, Xn=0x40) -> Yn=0x20.
REQ-036 Reset mid-MAC: RST=0 at tap 3 for 1 cycle -> out_valid stays 0, busy 0, next sample 0x40 with c reset -> Yn=0x00.
